// File: rtl/halflife_sequencer.sv
// halflife_sequencer
//   Drives an external N-bit up/down load counter through a radioactive
//   half-life decay. On start the counter is loaded with init_val. Each
//   half-life is a WAIT of half_period cycles, then a burst of down pulses
//   that takes the count to floor(count/2). This repeats until the count is 0.
//   The counter output is compared against an internal shadow copy during
//   every WAIT cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        begin a sequence (sampled in IDLE only)
//   abort        return to IDLE from any state; beats start
//   init_val     initial count, latched on an accepted start
//   half_period  WAIT length in cycles, latched on an accepted start (0 -> 1)
//   cnt_val      counter output, fed back for the consistency check
//   cnt_load     counter load strobe
//   cnt_up       counter up strobe (reserved, always 0)
//   cnt_down     counter down strobe
//   cnt_in       counter load data
//   busy         high in every state except IDLE
//   done         one-cycle pulse on normal completion
//   half_count   completed half-lives, saturating
//   err          sticky counter/shadow mismatch, cleared on an accepted start
module halflife_sequencer #(
   parameter int N = 4,
   parameter int P = 8,
   parameter int H = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [N-1:0] init_val,
   input  logic [P-1:0] half_period,
   input  logic [N-1:0] cnt_val,
   output logic         cnt_load,
   output logic         cnt_up,
   output logic         cnt_down,
   output logic [N-1:0] cnt_in,
   output logic         busy,
   output logic         done,
   output logic [H-1:0] half_count,
   output logic         err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT, S_DECAY, S_DONE
   } state_t;

   state_t         state_q;
   logic [N-1:0]   shadow_q;   // expected counter value
   logic [N-1:0]   steps_q;    // down pulses left in this burst
   logic [P-1:0]   period_q;
   logic [P-1:0]   timer_q;
   logic [N-1:0]   cnt_in_q;
   logic [H-1:0]   half_count_q;
   logic           err_q;

   logic [N-1:0]   steps_d;
   logic [P-1:0]   period_d;

   // ceil(shadow/2) pulses take the count down to floor(shadow/2).
   assign steps_d  = shadow_q - (shadow_q >> 1);
   assign period_d = (half_period == '0) ? P'(1) : half_period;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         shadow_q     <= '0;
         steps_q      <= '0;
         period_q     <= '0;
         timer_q      <= '0;
         cnt_in_q     <= '0;
         half_count_q <= '0;
         err_q        <= 1'b0;
      end else if (abort && state_q != S_IDLE) begin
         // Counter, half_count and err are deliberately left as they are.
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_q      <= S_LOAD;
                  shadow_q     <= init_val;
                  cnt_in_q     <= init_val;
                  period_q     <= period_d;
                  half_count_q <= '0;
                  err_q        <= 1'b0;
               end
            end
            S_LOAD: begin
               if (shadow_q == '0) begin
                  state_q <= S_DONE;
               end else begin
                  state_q <= S_WAIT;
                  timer_q <= period_q - P'(1);
               end
            end
            S_WAIT: begin
               if (cnt_val != shadow_q) err_q <= 1'b1;
               if (timer_q == '0) begin
                  steps_q <= steps_d;
                  state_q <= S_DECAY;
               end else begin
                  timer_q <= timer_q - P'(1);
               end
            end
            S_DECAY: begin
               shadow_q <= shadow_q - N'(1);
               steps_q  <= steps_q - N'(1);
               if (steps_q == N'(1)) begin
                  if (half_count_q != '1) half_count_q <= half_count_q + H'(1);
                  if (shadow_q == N'(1)) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_WAIT;
                     timer_q <= period_q - P'(1);
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Strobes decode straight from the state register, so no input reaches
   // an output combinationally, and load/down are mutually exclusive.
   assign cnt_load   = (state_q == S_LOAD);
   assign cnt_down   = (state_q == S_DECAY);
   assign cnt_up     = 1'b0;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign cnt_in     = cnt_in_q;
   assign half_count = half_count_q;
   assign err        = err_q;

endmodule

// File: tb/tb_halflife_sequencer.sv
module tb_halflife_sequencer;
   localparam int N = 4;
   localparam int P = 8;
   localparam int H = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [N-1:0] init_val = '0;
   logic [P-1:0] half_period = '0;
   logic [N-1:0] cnt_val;
   logic         cnt_load, cnt_up, cnt_down, busy, done, err;
   logic [N-1:0] cnt_in;
   logic [H-1:0] half_count;

   // Model of the external up/down load counter, with an override used to
   // inject a mismatch.
   logic [N-1:0] cnt_q = '0;
   logic         force_en = 1'b0;
   logic [N-1:0] force_v = '0;
   assign cnt_val = force_en ? force_v : cnt_q;

   int vectors = 0;
   int miscompares = 0;

   halflife_sequencer #(.N(N), .P(P), .H(H)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .init_val(init_val), .half_period(half_period), .cnt_val(cnt_val),
      .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_down(cnt_down),
      .cnt_in(cnt_in), .busy(busy), .done(done),
      .half_count(half_count), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cnt_load)      cnt_q <= cnt_in;
      else if (cnt_down) cnt_q <= cnt_q - 1'b1;
      else if (cnt_up)   cnt_q <= cnt_q + 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Starts a sequence and watches ncyc cycles (cycle 1 = LOAD).
   // fc: cycle in whose second half the counter reads as 5 (0 = never).
   task automatic run_seq(input logic [N-1:0] iv, input logic [P-1:0] hp,
                          input int ncyc, input int fc,
                          output int loads, output int downs, output int busys,
                          output int dones, output int done_idx,
                          output logic [31:0] dmask, output int viol,
                          output logic err_done);
      loads = 0; downs = 0; busys = 0; dones = 0; done_idx = 0;
      dmask = '0; viol = 0; err_done = 1'b0;
      @(negedge clk);
      start = 1'b1; init_val = iv; half_period = hp;
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         loads += int'(cnt_load);
         busys += int'(busy);
         if (cnt_down) begin downs++; dmask[i] = 1'b1; end
         if (done) begin dones++; done_idx = i; err_done = err; end
         if (cnt_up || (cnt_load && cnt_down)) viol++;
         force_en = (i == fc);
         force_v  = 4'd5;
      end
      force_en = 1'b0;
   endtask

   int          ld, dn, bz, dc, di, vl, ld4, dc4;
   logic [31:0] dm;
   logic        ed;

   initial begin
      // ---- reset state
      #2 rst = 1'b0;
      #1;
      chk("rst_cnt_load", cnt_load, 0);
      chk("rst_cnt_down", cnt_down, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt_in", cnt_in, 0);
      chk("rst_half_count", half_count, 0);
      chk("rst_err", err, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);

      // ---- 12 / 3: bursts 6,3,2,1
      run_seq(4'd12, 8'd3, 28, 0, ld, dn, bz, dc, di, dm, vl, ed);
      chk("t1_loads", ld, 1);
      chk("t1_downs", dn, 12);
      chk("t1_down_mask", dm, 32'h0231_C7E0);
      chk("t1_busy_cycles", bz, 26);
      chk("t1_done_count", dc, 1);
      chk("t1_done_cycle", di, 26);
      chk("t1_half_count", half_count, 4);
      chk("t1_err", err, 0);
      chk("t1_counter", cnt_q, 0);
      chk("t1_strobe_excl", vl, 0);

      // ---- 0 / 5: LOAD then DONE
      run_seq(4'd0, 8'd5, 4, 0, ld, dn, bz, dc, di, dm, vl, ed);
      chk("t2_loads", ld, 1);
      chk("t2_downs", dn, 0);
      chk("t2_done_cycle", di, 2);
      chk("t2_busy_cycles", bz, 2);
      chk("t2_half_count", half_count, 0);

      // ---- 15 / 0: period treated as 1, bursts 8,4,2,1
      run_seq(4'd15, 8'd0, 23, 0, ld, dn, bz, dc, di, dm, vl, ed);
      chk("t3_downs", dn, 15);
      chk("t3_down_mask", dm, 32'h0016_F7F8);
      chk("t3_done_cycle", di, 21);
      chk("t3_half_count", half_count, 4);
      chk("t3_counter", cnt_q, 0);
      chk("t3_err", err, 0);

      // ---- 9 / 4, start while busy ignored, abort in 2nd DECAY cycle
      ld4 = 0; dc4 = 0;
      @(negedge clk);
      start = 1'b1; init_val = 4'd9; half_period = 8'd4;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         ld4 += int'(cnt_load);
         dc4 += int'(done);
         if (i == 1) start = 1'b0;
         if (i == 3) begin start = 1'b1; init_val = 4'd2; end
         if (i == 4) start = 1'b0;
         if (i == 7) begin
            chk("t4_down_c7", cnt_down, 1);
            abort = 1'b1;
         end
         if (i == 8) begin
            abort = 1'b0;
            chk("t4_busy_after_abort", busy, 0);
            chk("t4_down_after_abort", cnt_down, 0);
            chk("t4_half_count", half_count, 0);
            chk("t4_counter_abort", cnt_q, 7);
         end
      end
      chk("t4_loads", ld4, 1);
      chk("t4_no_done", dc4, 0);
      chk("t4_cnt_in", cnt_in, 9);
      chk("t4_counter_held", cnt_q, 7);
      chk("t4_err", err, 0);

      // start together with abort in IDLE stays IDLE
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("t4_start_abort_busy", busy, 0);
      chk("t4_start_abort_load", cnt_load, 0);

      // ---- 6 / 3 with counter forced to 5 during WAIT
      run_seq(4'd6, 8'd3, 19, 3, ld, dn, bz, dc, di, dm, vl, ed);
      chk("t5_done_cycle", di, 17);
      chk("t5_err_at_done", ed, 1);
      chk("t5_err_idle", err, 1);
      chk("t5_half_count", half_count, 3);
      run_seq(4'd1, 8'd1, 6, 0, ld, dn, bz, dc, di, dm, vl, ed);
      chk("t5b_done_cycle", di, 4);
      chk("t5b_err_cleared", ed, 0);
      chk("t5b_half_count", half_count, 1);

      // ---- async reset mid-WAIT
      @(negedge clk);
      start = 1'b1; init_val = 4'd12; half_period = 8'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6_busy_before", busy, 1);
      #2 rst = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_cnt_in", cnt_in, 0);
      chk("t6_half_count", half_count, 0);
      chk("t6_load_down", {cnt_load, cnt_down, done, err}, 0);
      #3 rst = 1'b1;
      @(negedge clk);
      chk("t6_idle_after", busy, 0);
      run_seq(4'd12, 8'd3, 28, 0, ld, dn, bz, dc, di, dm, vl, ed);
      chk("t6_rerun_done_cycle", di, 26);
      chk("t6_rerun_half_count", half_count, 4);
      chk("t6_rerun_counter", cnt_q, 0);
      chk("t6_rerun_err", err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/halflife_sequencer.md
Name: halflife_sequencer

Overview:
Controller that sequences the team's n-bit up/down load counter to model radioactive half-life decay. On start it loads an initial count into the counter. After each programmable half-life period it issues single-cycle down pulses until the counter value is halved (floor), and it repeats until the count reaches zero. It sits beside the counter, drives the counter's load/up/down/in controls, and monitors the counter output for consistency.

Parameters:
N, 4, counter data width (must match the counter's n)
P, 8, half-life period register width (cycles)
H, 4, width of the elapsed half-life counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  begin sequence; sampled only in IDLE
abort  input  1  return to IDLE from any state; takes priority over start
init_val  input  N  initial count, latched on accepted start
half_period  input  P  cycles per WAIT phase, latched on accepted start; 0 treated as 1
cnt_val  input  N  counter output, fed back
cnt_load  output  1  counter load strobe
cnt_up  output  1  counter up strobe, tied 0 (reserved)
cnt_down  output  1  counter down strobe
cnt_in  output  N  counter load data
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on normal completion
half_count  output  H  number of completed half-lives; saturates at 2^H-1
err  output  1  sticky mismatch flag; cleared on accepted start

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, including cnt_in, half_count and err. Internal shadow, timer and steps registers are 0.
- All outputs are registered or decoded from state registers only. There is no combinational path from inputs to outputs.
- IDLE:
  - start=1 and abort=0 → LOAD.
  - On that transition: latch init_val into shadow and cnt_in, latch max(half_period,1) into the period register, clear half_count and err.
- LOAD (1 cycle): cnt_load=1, cnt_in=shadow.
  - If shadow==0 → DONE.
  - Otherwise → WAIT, with timer=period-1.
- WAIT: lasts exactly period cycles; timer decrements each cycle.
  - err is set if cnt_val!=shadow in any WAIT cycle.
  - When timer==0: steps = shadow - (shadow>>1), i.e. ceil(shadow/2). Go to DECAY.
- DECAY: cnt_down=1 for exactly steps consecutive cycles. Each cycle, shadow and steps both decrement.
  - After the final pulse, half_count increments (saturating).
  - If new shadow==0 → DONE. Otherwise → WAIT, with timer reloaded to period-1.
- DONE (1 cycle): done=1, busy=1 → IDLE.
- Cycle counts:
  - Counter is updated at the clock edge ending each strobe cycle.
  - Total sequence length = 1 (LOAD) + sum over half-lives of (period + steps) + 1 (DONE).
- Boundaries:
  - shadow=1: steps=1, then DONE.
  - init_val=0: LOAD, then DONE directly; half_count=0.
  - init_val=2^N-1: arithmetic stays within N bits; no wrap.
- Abort, in any non-IDLE state:
  - Next cycle is IDLE; cnt_load, cnt_down and busy deassert that cycle.
  - No done pulse.
  - half_count and err hold their values; the counter keeps whatever value it had.
- start while busy: ignored. start and abort together in IDLE: stay IDLE.
- Reset mid-sequence: immediate return to the reset values; no done pulse.
- cnt_up and cnt_load are never asserted together with cnt_down.

Test Plan:
- init_val=12, half_period=3 → cnt_load for 1 cycle. Then, per half-life, 3 WAIT cycles followed by down-pulse bursts of 6, 3, 2 and 1 (counter goes 12→6→3→1→0). done pulses on cycle 26 after start; half_count=4; err=0; busy high for 26 cycles.
- init_val=0, half_period=5 → LOAD, then done on the next cycle; half_count=0; no cnt_down.
- init_val=15, half_period=0 → period treated as 1. Bursts of 8, 4, 2, 1 (15→7→3→1→0); half_count=4.
- Start 9/period 4, abort asserted during the second DECAY cycle → IDLE the following cycle. No done; half_count=0; counter holds 7 (two pulses applied). A start during the run before the abort is ignored.
- Counter model forced to 5 while shadow=6 in WAIT → err=1 and stays 1 through DONE; the next accepted start clears it.
- rst pulsed low mid-WAIT, asynchronous to clk → all outputs 0 immediately; state=IDLE after release; a new start runs normally.
